// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the HILO path.
// Holds the pipeline via stall_request and emits one HILO write per operation.
module muldiv_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int MUL_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] operand_1,
   input  logic [DATA_WIDTH-1:0] operand_2,
   input  logic                  flush,
   output logic                  busy,
   output logic                  stall_request,
   output logic                  hilo_write_en,
   output logic [DATA_WIDTH-1:0] hi_out,
   output logic [DATA_WIDTH-1:0] lo_out
);
   localparam int W    = DATA_WIDTH;
   localparam int CW   = $clog2(DATA_WIDTH + 8);
   localparam int MCNT = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t          state, state_next;
   logic            accept;
   logic [CW-1:0]   cnt;
   logic            sgn_q;
   logic [W-1:0]    a_q, b_q, b_mag, rem, quo, hi_q, lo_q;

   logic            mul_sgn;
   logic [W-1:0]    mul_a, mul_b;
   logic [2*W-1:0]  ext_a, ext_b, prod;
   logic [W:0]      trial, diff;
   logic [W-1:0]    rem_nxt, quo_nxt, q_fix, r_fix;
   logic [W-1:0]    dvd_mag, dvs_mag;
   logic            q_neg, r_neg;
   logic            wr_mul, wr_div;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !flush) begin
               accept = 1'b1;
               if (op[1])                 state_next = DIV;
               else if (MUL_LATENCY == 1) state_next = DONE;
               else                       state_next = MUL;
            end
         end
         MUL, DIV: begin
            if (flush)           state_next = IDLE;
            else if (cnt == '0)  state_next = DONE;
         end
         DONE: state_next = IDLE;
      endcase
   end

   assign busy          = (state != IDLE);
   assign stall_request = (start && state == IDLE && !flush)
                        || (busy && state != DONE);
   assign hilo_write_en = (state == DONE) && !flush;
   assign hi_out        = hi_q;
   assign lo_out        = lo_q;

   // A single-cycle multiply has to read the live inputs on the accept edge.
   always_comb begin
      if (state == IDLE) begin
         mul_a   = operand_1;
         mul_b   = operand_2;
         mul_sgn = !op[0];
      end else begin
         mul_a   = a_q;
         mul_b   = b_q;
         mul_sgn = sgn_q;
      end
      ext_a = mul_sgn ? {{W{mul_a[W-1]}}, mul_a} : {{W{1'b0}}, mul_a};
      ext_b = mul_sgn ? {{W{mul_b[W-1]}}, mul_b} : {{W{1'b0}}, mul_b};
      prod  = ext_a * ext_b;
   end

   always_comb begin
      dvd_mag = (!op[0] && operand_1[W-1]) ? -operand_1 : operand_1;
      dvs_mag = (!op[0] && operand_2[W-1]) ? -operand_2 : operand_2;
      trial   = {rem, quo[W-1]};
      diff    = trial - {1'b0, b_mag};
      rem_nxt = diff[W] ? trial[W-1:0] : diff[W-1:0];
      quo_nxt = {quo[W-2:0], !diff[W]};
      q_neg   = sgn_q && (a_q[W-1] ^ b_q[W-1]);
      r_neg   = sgn_q && a_q[W-1];
      q_fix   = q_neg ? -quo_nxt : quo_nxt;
      r_fix   = r_neg ? -rem_nxt : rem_nxt;
   end

   assign wr_mul = (state_next == DONE) && (state == IDLE || state == MUL);
   assign wr_div = (state_next == DONE) && (state == DIV);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         sgn_q <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         b_mag <= '0;
         rem   <= '0;
         quo   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         if (accept) begin
            sgn_q <= !op[0];
            a_q   <= operand_1;
            b_q   <= operand_2;
            b_mag <= dvs_mag;
            rem   <= '0;
            quo   <= dvd_mag;
            cnt   <= op[1] ? CW'(W - 1) : CW'(MCNT);
         end else if ((state == MUL || state == DIV) && !flush
                      && cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
         if (state == DIV && !flush) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
         end
         if (wr_mul) begin
            hi_q <= prod[2*W-1:W];
            lo_q <= prod[W-1:0];
         end
         // Zero divisor bypasses the sign fixup: remainder is the raw dividend.
         if (wr_div) begin
            if (b_q == '0) begin
               hi_q <= a_q;
               lo_q <= '1;
            end else begin
               hi_q <= r_fix;
               lo_q <= q_fix;
            end
         end
      end
   end
endmodule
